// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-master arbiter for the shared RAM/GPO/GPI data bus.
// Define ARB_TIMEOUT_EN to abort transfers whose slave never asserts bus_ready.
module bus_arbiter
`ifdef ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_done,
    output logic        m1_done,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ready
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;
    state_e      state_q, state_d;
    logic        owner_q, owner_d, last_q, last_d, we_q, we_d, err_q, err_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic        sel, mapped;
    logic [31:0] req_addr;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired;
    assign expired = cnt_q == CW'(TIMEOUT - 1);
`endif
    // on a tie the master not served last wins
    assign sel      = (m0_req && m1_req) ? !last_q : m1_req;
    assign req_addr = sel ? m1_addr : m0_addr;
    assign mapped   = req_addr[31:8] == 24'h000010 || req_addr[31:8] == 24'h000020 ||
                      req_addr[31:8] == 24'h000021;
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        err_d    = err_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: if (m0_req || m1_req) begin
                owner_d = sel;
                addr_d  = req_addr;
                we_d    = sel ? m1_we : m0_we;
                wdata_d = sel ? m1_wdata : m0_wdata;
                err_d   = !mapped;
                state_d = mapped ? XFER : DONE;
`ifdef ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            XFER: if (bus_ready) begin
                rdata0_d = (!we_q && !owner_q) ? bus_rdata : rdata0_q;
                rdata1_d = (!we_q && owner_q) ? bus_rdata : rdata1_q;
                err_d    = 1'b0;
                state_d  = DONE;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                cnt_d   = cnt_q + 1'b1;
                err_d   = expired;
                state_d = expired ? DONE : XFER;
            end
`endif
            DONE: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            err_q    <= err_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end
    assign m0_gnt    = state_q != IDLE && !owner_q;
    assign m1_gnt    = state_q != IDLE && owner_q;
    assign m0_done   = state_q == DONE && !owner_q;
    assign m1_done   = state_q == DONE && owner_q;
    assign m0_err    = m0_done && err_q;
    assign m1_err    = m1_done && err_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign bus_en    = state_q == XFER;
    assign bus_we    = bus_en && we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized checks of bus_arbiter against a transaction-level model.
module tb_bus_arbiter;
    logic        clk, reset;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_en, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    int          checks = 0, fails = 0;
    bit          chk_en = 0;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif
    bus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_done(m0_done), .m1_done(m1_done),
        .m0_err(m0_err), .m1_err(m1_err), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ready(bus_ready)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    // transaction model: ph 0 = no transaction, 1 = on the bus, 2 = reporting completion
    int          ph = 0, waited = 0;
    bit          own = 0, prev = 1, m_we = 0, m_err = 0;
    logic [31:0] m_addr = 0, m_wdata = 0;
    logic [31:0] m_rd [2];
    function automatic bit mapped(input logic [31:0] a);
        return a[31:8] inside {24'h000010, 24'h000020, 24'h000021};
    endfunction
    function automatic bit exp_done(input bit x);
        return ph == 2 && own == x;
    endfunction
    task automatic model_step();
        bit w;
        if (reset) begin
            ph = 0; prev = 1; own = 0; m_we = 0; m_err = 0;
            m_addr = 0; m_wdata = 0; m_rd[0] = 0; m_rd[1] = 0;
        end else if (ph == 2) begin
            prev = own;
            ph = 0;
        end else if (ph == 1) begin
            if (bus_ready) begin
                if (!m_we) m_rd[own] = bus_rdata;
                m_err = 0;
                ph = 2;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                waited++;
                if (waited == TO) begin
                    m_err = 1;
                    ph = 2;
                end
            end
`endif
        end else if (m0_req || m1_req) begin
            w = (m0_req && m1_req) ? !prev : m1_req;
            own = w;
            m_addr = w ? m1_addr : m0_addr;
            m_we = w ? m1_we : m0_we;
            m_wdata = w ? m1_wdata : m0_wdata;
            m_err = !mapped(m_addr);
            ph = m_err ? 2 : 1;
            waited = 0;
        end
    endtask
    initial forever begin
        @(posedge clk);
        model_step();
    end
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("flags", 32'({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, bus_en, bus_we}),
                32'({ph != 0 && !own, ph != 0 && own, exp_done(0), exp_done(1),
                     exp_done(0) && m_err, exp_done(1) && m_err, ph == 1, ph == 1 && m_we}));
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_wdata", bus_wdata, m_wdata);
            chk("m0_rdata", m0_rdata, m_rd[0]);
            chk("m1_rdata", m1_rdata, m_rd[1]);
        end
    end
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        reset = 1; m0_req = 0; m1_req = 0; bus_ready = 0;
        cyc();
        cyc();
        reset = 0;
    endtask
    function automatic logic [31:0] rand_addr();
        logic [7:0] lo = 8'($urandom);
        case ($urandom_range(0, 3))
            0: return {24'h000010, lo};
            1: return {24'h000020, lo};
            2: return {24'h000021, lo};
            default: return $urandom;
        endcase
    endfunction
    task automatic drive_master(input bit dn, inout logic req, inout logic we,
                                inout logic [31:0] a, inout logic [31:0] d);
        if (req && dn) req = 1'b0;
        else if (!req && $urandom_range(0, 2) == 0) begin
            req = 1'b1;
            we = 1'($urandom);
            a = rand_addr();
            d = $urandom;
        end
    endtask
    initial begin
        m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        bus_rdata = 0;
        do_reset();
        chk_en = 1;
        chk("reset_flags", 32'({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, bus_en, bus_we}), 32'h0);
        chk("reset_addr", bus_addr, 32'h0);
        // single read by master 0
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_1004; bus_ready = 1; bus_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("t1_xfer", 32'({bus_en, m0_gnt, m1_gnt}), 32'h6);
        chk("t1_addr", bus_addr, 32'h0000_1004);
        cyc();
        chk("t1_done", 32'({m0_done, m0_err, bus_en}), 32'h4);
        chk("t1_rdata", m0_rdata, 32'hDEAD_BEEF);
        m0_req = 0; bus_ready = 0;
        cyc();
        chk("t1_idle", 32'({m0_gnt, m0_done}), 32'h0);
        // fairness with both masters held
        do_reset();
        m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0;
        m0_addr = 32'h0000_1000; m1_addr = 32'h0000_2100; bus_ready = 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            for (int n = 0; n < 10 && !(m0_done || m1_done); n++) cyc();
            chk("fair_winner", 32'({m1_done, m0_done}), (k % 2) ? 32'h2 : 32'h1);
        end
        // write with a slow slave; bus stays stable while the master inputs wander
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h0000_2000; m1_wdata = 32'h0000_00FF;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("t3_bus", 32'({bus_en, bus_we, m1_gnt, m1_done}), 32'hE);
            chk("t3_addr", bus_addr, 32'h0000_2000);
            chk("t3_wdata", bus_wdata, 32'h0000_00FF);
            m1_addr = $urandom; m1_wdata = $urandom;
            if (i == 4) bus_ready = 1;
            cyc();
        end
        chk("t3_done", 32'({m1_done, m1_err, m0_done, bus_en}), 32'h8);
        chk("t3_rdata", m1_rdata, 32'h0);
        m1_req = 0; bus_ready = 0;
        cyc();
        // unmapped address
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_3000;
        cyc();
        chk("t4_err", 32'({m0_done, m0_err, bus_en, m0_gnt}), 32'hD);
        m0_req = 0;
        cyc();
        chk("t4_idle", 32'({m0_done, bus_en}), 32'h0);
        // slave that never answers
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0000_2100;
        cyc();
`ifdef ARB_TIMEOUT_EN
        begin
            int n = 0;
            while (bus_en && n < 40) begin
                n++;
                cyc();
            end
            chk("to_cycles", 32'(n), 32'd16);
        end
        chk("to_done", 32'({m0_done, m0_err, bus_en}), 32'h6);
        m0_req = 0;
        cyc();
`else
        repeat (100) cyc();
        chk("no_timeout", 32'({bus_en, m0_gnt, m0_done}), 32'h6);
        bus_ready = 1;
        cyc();
        chk("late_done", 32'({m0_done, m0_err}), 32'h2);
        m0_req = 0; bus_ready = 0;
        cyc();
`endif
        // reset in the middle of a transfer
        do_reset();
        m1_req = 1; m1_we = 0; m1_addr = 32'h0000_1008; bus_rdata = 32'h1234_5678;
        cyc();
        chk("t6_xfer", 32'(bus_en), 32'h1);
        reset = 1; m1_req = 0;
        cyc();
        chk("t6_flags", 32'({m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, bus_en, bus_we}), 32'h0);
        chk("t6_addr", bus_addr, 32'h0);
        reset = 0;
        cyc();
        chk("t6_nodone", 32'({m1_done, m1_gnt}), 32'h0);
        // randomized traffic
        repeat (3000) begin
            cyc();
            reset = $urandom_range(0, 299) == 0;
            bus_ready = $urandom_range(0, 2) == 0;
            bus_rdata = $urandom;
            drive_master(exp_done(0), m0_req, m0_we, m0_addr, m0_wdata);
            drive_master(exp_done(1), m1_req, m1_we, m1_addr, m1_wdata);
        end
        cyc();
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
